// File: rtl/icache_resp.sv
// Direct-mapped, one-word-per-line instruction cache responder with req/ack refill port.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req_valid_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    input  logic              icache_data_wen_i,
    output logic              icache_data_valid_o,
    output logic [DATA_W-1:0] icache_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [31:0]       perf_hit_cnt_o,
    output logic [31:0]       perf_miss_cnt_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        HIT_RESP,
        REFILL,
        MISS_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-3:0]   req_word_q, req_word_d;
    logic                data_valid_q, data_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic [IDX_W-1:0]    lookup_idx;
    logic [TAG_W-1:0]    lookup_tag;
    logic                lookup_hit;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                fill_we;
    logic                hit_inc;
    logic                miss_inc;

    // Byte-offset bits never take part in lookup or refill addressing.
    logic [1:0] unused_addr_bits;
    assign unused_addr_bits = icache_addr_i[1:0];

    assign lookup_idx = icache_addr_i[IDX_W+1:2];
    assign lookup_tag = icache_addr_i[ADDR_W-1:IDX_W+2];
    assign lookup_hit = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign fill_idx   = req_word_q[IDX_W-1:0];
    assign fill_tag   = req_word_q[ADDR_W-3:IDX_W];

    always_comb begin
        state_d      = state_q;
        req_word_d   = req_word_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        fill_we      = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (icache_req_valid_i) begin
                    req_word_d = icache_addr_i[ADDR_W-1:2];
                    if (icache_data_wen_i) begin
                        if (lookup_hit) begin
                            valid_d[lookup_idx] = 1'b0;
                        end
                        data_valid_d = 1'b1;
                        data_d       = '0;
                        state_d      = HIT_RESP;
                    end else if (lookup_hit) begin
                        data_valid_d = 1'b1;
                        data_d       = data_mem[lookup_idx];
                        hit_inc      = 1'b1;
                        state_d      = HIT_RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {icache_addr_i[ADDR_W-1:2], 2'b00};
                        miss_inc   = 1'b1;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    mem_req_d         = 1'b0;
                    data_valid_d      = 1'b1;
                    data_d            = mem_data_i;
                    state_d           = MISS_RESP;
                end
            end
            HIT_RESP, MISS_RESP: state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_word_q   <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_word_q   <= req_word_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data_i;
        end
    end

    assign icache_data_valid_o = data_valid_q;
    assign icache_data_o       = data_q;
    assign mem_req_o           = mem_req_q;
    assign mem_addr_o          = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_inc && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
`else
    logic unused_perf;
    assign unused_perf     = hit_inc ^ miss_inc;
    assign perf_hit_cnt_o  = '0;
    assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: cold miss, hit, conflict eviction, invalidate,
// reset during refill and (with ICACHE_PERF_CNT_EN) the performance counters.
module tb_icache_resp;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic        data_valid;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;

    icache_resp #(
        .ADDR_W(32),
        .DATA_W(32),
        .IDX_W (6)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .icache_req_valid_i (req_valid),
        .icache_addr_i      (req_addr),
        .icache_data_wen_i  (req_wen),
        .icache_data_valid_o(data_valid),
        .icache_data_o      (data),
        .mem_req_o          (mem_req),
        .mem_addr_o         (mem_addr),
        .mem_ack_i          (mem_ack),
        .mem_data_i         (mem_data),
        .perf_hit_cnt_o     (hit_cnt),
        .perf_miss_cnt_o    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ack_dly = 0 means the access must be served without memory traffic;
    // otherwise ack is returned in the ack_dly-th cycle of mem_req.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic wen,
                         input int ack_dly, input logic [31:0] exp_data);
        int          cyc;
        int          memcyc;
        bit          got;
        logic [31:0] got_data;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        mem_ack   = 1'b0;
        cyc       = 0;
        memcyc    = 0;
        got       = 1'b0;
        got_data  = '0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            req_addr = 32'hDEAD_BEEC;
            req_wen  = 1'b0;
            mem_ack  = 1'b0;
            if (mem_req) begin
                memcyc++;
                if (memcyc == 1) check({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
                if (memcyc == ack_dly) begin
                    mem_ack  = 1'b1;
                    mem_data = exp_data;
                end
            end
            if (data_valid) begin
                got       = 1'b1;
                got_data  = data;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        check({tag, "_resp"}, 32'(got), 32'd1);
        check({tag, "_lat"}, cyc, (ack_dly == 0) ? 32'd1 : 32'(ack_dly + 1));
        check({tag, "_memcyc"}, memcyc, ack_dly);
        check({tag, "_data"}, got_data, exp_data);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dv_seen;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_dv",    32'(data_valid), 32'd0);
        check("rst_data",  data, 32'd0);
        check("rst_mreq",  32'(mem_req), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_hit",   hit_cnt, 32'd0);
        check("rst_miss",  miss_cnt, 32'd0);
        rst = 1'b1;

        fetch("cold",    32'h0000_0000, 1'b0, 3, 32'h0000_0013);
        fetch("rehit",   32'h0000_0000, 1'b0, 0, 32'h0000_0013);
        fetch("c100",    32'h0000_0100, 1'b0, 2, 32'h0000_00A1);
        fetch("c000",    32'h0000_0000, 1'b0, 1, 32'h0000_0093);
        fetch("c000hit", 32'h0000_0002, 1'b0, 0, 32'h0000_0093);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit",  hit_cnt, 32'd2);
        check("perf_miss", miss_cnt, 32'd3);
`else
        check("perf_hit",  hit_cnt, 32'd0);
        check("perf_miss", miss_cnt, 32'd0);
`endif

        fetch("inval",   32'h0000_0000, 1'b1, 0, 32'h0000_0000);
        fetch("postinv", 32'h0000_0000, 1'b0, 2, 32'h0000_0037);
        fetch("reinval", 32'h0000_0000, 1'b0, 0, 32'h0000_0037);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit2",  hit_cnt, 32'd3);
        check("perf_miss2", miss_cnt, 32'd4);
`endif

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0008;
        req_wen   = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_req_up", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mr_req_drop", 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        dv_seen   = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_valid || mem_req) dv_seen++;
        end
        check("mr_quiet", 32'(dv_seen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_hit_cnt",  hit_cnt, 32'd0);
        check("mr_miss_cnt", miss_cnt, 32'd0);
        fetch("postrst", 32'h0000_0000, 1'b0, 2, 32'h0000_0055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
